// File: rtl/neural_pipe_pkg.sv
// Shared types and helpers for the velocity frame packer: FSM encoding,
// frame layout and the 16-bit position clamp.
package neural_pipe_pkg;

    localparam int         FRAME_BYTES       = 7;
    localparam logic [7:0] FRAME_HDR_DEFAULT = 8'hA5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } fsm_state_t;

    function automatic logic signed [15:0] sat16(
        input logic signed [16:0] val,
        input logic signed [15:0] lo,
        input logic signed [15:0] hi
    );
        logic signed [16:0] lo_x;
        logic signed [16:0] hi_x;
        lo_x = lo;
        hi_x = hi;
        if (val < lo_x) begin
            return lo;
        end else if (val > hi_x) begin
            return hi;
        end
        return val[15:0];
    endfunction

    // Byte 0 sits in the top byte so the sender can shift left one byte per handshake.
    function automatic logic [FRAME_BYTES*8-1:0] build_frame(
        input logic [7:0]  hdr,
        input logic [7:0]  seq,
        input logic [15:0] mean,
        input logic [15:0] pos
    );
        logic [7:0] chk;
        chk = hdr ^ seq ^ mean[15:8] ^ mean[7:0] ^ pos[15:8] ^ pos[7:0];
        return {hdr, seq, mean, pos, chk};
    endfunction

endpackage

// File: rtl/velocity_frame_packer_if.sv
// Byte stream toward the host link: valid/ready handshake carrying one frame byte.
interface velocity_frame_packer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/velocity_frame_packer_bin.sv
// Bin averager: sums 2^BIN_LOG2 valid samples and strobes bin_done with the
// floor mean during the cycle that carries the final sample.
module bin_accumulator #(
    parameter int BIN_LOG2 = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] vel_in,
    input  logic               vel_valid,
    output logic               bin_done,
    output logic signed [15:0] mean
);
    localparam int ACC_W = 16 + BIN_LOG2;

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W-1:0] acc_shift;
    logic [BIN_LOG2-1:0]     count;

    assign acc_sum   = acc + ACC_W'(vel_in);
    assign acc_shift = acc_sum >>> BIN_LOG2;
    assign mean      = acc_shift[15:0];
    assign bin_done  = vel_valid && (count == '1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            count <= '0;
        end else if (vel_valid) begin
            count <= count + 1'b1;
            acc   <= bin_done ? '0 : acc_sum;
        end
    end
endmodule

// File: rtl/velocity_frame_packer.sv
// Averages velocity into bins, integrates bin means into a clamped position and
// streams one 7-byte frame per bin, dropping bins when the link falls behind.
//   state   | meaning
//   ST_IDLE | waiting for a pending frame; moves it into the shift buffer
//   ST_SEND | presenting frame bytes one per handshake, idx 0..6
module velocity_frame_packer
    import neural_pipe_pkg::*;
#(
    parameter int                BIN_LOG2  = 9,
    parameter logic signed [15:0] POS_MIN  = 16'sh8000,
    parameter logic signed [15:0] POS_MAX  = 16'sh7FFF,
    parameter logic [7:0]        FRAME_HDR = FRAME_HDR_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic signed [15:0]        vel_in,
    input  logic                      vel_valid,
    input  logic                      pos_clear,
    velocity_frame_packer_if.master   tx,
    output logic signed [15:0]        pos_out,
    output logic                      overflow,
    output logic [7:0]                drop_count
);
    logic               bin_done;
    logic signed [15:0] bin_mean;
    logic signed [16:0] pos_sum;
    logic signed [15:0] pos_upd;

    logic               pend_valid;
    logic [7:0]         pend_seq;
    logic [15:0]        pend_mean;
    logic [15:0]        pend_pos;
    logic [7:0]         seq;

    fsm_state_t                 state, state_next;
    logic [2:0]                 idx, idx_next;
    logic [FRAME_BYTES*8-1:0]   frame_buf;
    logic                       drain;
    logic                       shift;
    logic                       load_pending;

    bin_accumulator #(.BIN_LOG2(BIN_LOG2)) u_bin (
        .clk       (clk),
        .rst       (rst),
        .vel_in    (vel_in),
        .vel_valid (vel_valid),
        .bin_done  (bin_done),
        .mean      (bin_mean)
    );

    assign pos_sum      = 17'(pos_out) + 17'(bin_mean);
    assign pos_upd      = pos_clear ? 16'sd0 : sat16(pos_sum, POS_MIN, POS_MAX);
    // A bin landing while the FSM empties the pending slot takes the slot.
    assign load_pending = bin_done && (!pend_valid || drain);

    always_ff @(posedge clk) begin
        if (!rst) begin
            pos_out    <= '0;
            seq        <= '0;
            pend_valid <= 1'b0;
            pend_seq   <= '0;
            pend_mean  <= '0;
            pend_pos   <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (bin_done) begin
                pos_out <= pos_upd;
                seq     <= seq + 8'd1;
            end else if (pos_clear) begin
                pos_out <= '0;
            end

            if (load_pending) begin
                pend_valid <= 1'b1;
                pend_seq   <= seq;
                pend_mean  <= bin_mean;
                pend_pos   <= pos_upd;
            end else if (drain) begin
                pend_valid <= 1'b0;
            end

            if (bin_done && !load_pending) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            frame_buf <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            if (drain) begin
                frame_buf <= build_frame(FRAME_HDR, pend_seq, pend_mean, pend_pos);
            end else if (shift) begin
                frame_buf <= {frame_buf[FRAME_BYTES*8-9:0], 8'h00};
            end
        end
    end

    always_comb begin
        state_next  = state;
        idx_next    = idx;
        drain       = 1'b0;
        shift       = 1'b0;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;
        case (state)
            ST_IDLE: begin
                if (pend_valid) begin
                    drain      = 1'b1;
                    state_next = ST_SEND;
                    idx_next   = 3'd0;
                end
            end
            ST_SEND: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = frame_buf[FRAME_BYTES*8-1 -: 8];
                if (tx.tx_ready) begin
                    shift = 1'b1;
                    if (idx == 3'(FRAME_BYTES - 1)) begin
                        state_next = ST_IDLE;
                    end else begin
                        idx_next = idx + 3'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule
